// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, load, shifts, rotates, arithmetic shift right and clear,
// plus a saturating shift counter so a controller can sequence serial<->parallel conversion.
`timescale 1ns/1ps
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin_l,
  input  logic                         sin_r,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_l,
  output logic                         sout_r,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // Counter parks at WIDTH; q keeps shifting after that.
  assign cnt_inc = (cnt_q == CW'(WIDTH)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    q_d   = q_q;
    cnt_d = cnt_q;
    if (en) begin
      case (mode_sel)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], sin_r};
          cnt_d = cnt_inc;
        end
        MODE_SHR: begin
          q_d   = {sin_l, q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_ROL: begin
          q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          cnt_d = cnt_inc;
        end
        MODE_ROR: begin
          q_d   = {q_q[0], q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_ASR: begin
          q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign cnt    = cnt_q;
  assign full   = (cnt_q == CW'(WIDTH));

endmodule
